cmd_uart_tx: RTL
================

# cmd_uart_tx

Parametrised command transmitter: accepts command words from the control logic over a valid/ready handshake, buffers them in an internal FIFO, and serialises each word as an asynchronous 8N1-style UART frame on `tx`. It replaces the fixed single-command transmit path with configurable word width, baud divisor, stop-bit count and buffer depth. It also provides back-to-back frame streaming and an optional parity bit.

## Interface
- `CLKS_PER_BIT`, default 434: `clk` cycles per UART bit; ≥2.
- `DATA_W`, default 8: command word width; 5..8.
- `FIFO_DEPTH`, default 8: command buffer entries; power of two, ≥2.
- `STOP_BITS`, default 1: stop bits per frame; 1 or 2.
- `clk` input, 1 bit: system clock, rising edge.
- `rst` input, 1 bit: asynchronous reset, active-high.
- `cmd` input, DATA_W bits: command word.
- `cmd_valid` input, 1 bit: `cmd` is valid this cycle.
- `cmd_ready` output, 1 bit: FIFO can accept a word; equals !full.
- `tx` output, 1 bit: serial line; idle high.
- `busy` output, 1 bit: high while a frame is on the line or the FIFO is non-empty.
- `fifo_level` output, $clog2(FIFO_DEPTH+1) bits: current FIFO occupancy.

## Operation
- Reset (async, `rst`=1): `tx`=1, `busy`=0, `cmd_ready`=0 while `rst` is high, then 1. `fifo_level`=0, FIFO pointers=0, FSM=IDLE, bit timer=0, bit index=0.
- Push: a word is written on a rising edge with `cmd_valid && cmd_ready`. `cmd_valid` while full is ignored, and the word is dropped by the producer's responsibility.
- Pop: occurs on the edge where the FSM leaves IDLE, or leaves the last STOP bit, with the FIFO non-empty. The popped word is latched into the shift register.
- A push and a pop on the same edge leave `fifo_level` unchanged.
- FSM states:
  - IDLE: `tx`=1. If FIFO is non-empty, pop and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with index 0.
  - DATA: `tx`=shift[0], sent LSB first. Each bit is held for CLKS_PER_BIT cycles, then the register shifts right. After bit DATA_W-1, go to PARITY if enabled, else STOP.
  - PARITY: `tx`=even parity, i.e. the XOR of all DATA_W bits. Held for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Bit timer counts 0..CLKS_PER_BIT-1. A bit boundary occurs when the timer equals CLKS_PER_BIT-1, after which the timer wraps to 0.
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Full/empty are derived from `fifo_level`.
- `rst` asserted mid-frame aborts the frame immediately, with `tx` driven to 1 asynchronously. Buffered words are discarded.

## Timing
- `tx`, `busy`, `cmd_ready` and `fifo_level` are registered outputs; there is no combinational path from the inputs.
- Latency, idle block with empty FIFO:
  - Push at edge N makes `fifo_level`=1 after N.
  - Pop at edge N+1 drives `tx` low after N+1 and returns `fifo_level` to 0.
- Frame length: (1 + DATA_W + P + STOP_BITS)×CLKS_PER_BIT cycles, where P=1 with parity, else 0.
- Consecutive buffered words: the start bit of word k+1 immediately follows the last stop bit of word k.
- `cmd_ready` deasserts on the edge that makes the FIFO full. It reasserts on the edge of the next pop.
- `busy` goes high on the edge after the first push and low on the edge that enters IDLE with an empty FIFO.

## Configuration
- `CMD_UART_PARITY_EN` defined: the PARITY state is compiled in and every frame carries one even-parity bit after the data bits.
- `CMD_UART_PARITY_EN` not defined: the PARITY state and parity logic are absent; frames are start + DATA_W data + STOP_BITS stop.

## Test plan
- Reset check: hold `rst`=1 for 5 cycles, then release. Required: `tx`=1, `busy`=0, `fifo_level`=0, and `cmd_ready`=1 one cycle after release.
- Single frame (CLKS_PER_BIT=4, DATA_W=8, no parity): push 0xA5. Required: `tx` bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, 40 cycles total; then `busy`=0.
- Parity (macro defined): push 0xA5, then 0x07. Required: parity bit 0 for 0xA5 and 1 for 0x07, each frame 44 cycles, no gap between frames.
- Back-pressure (FIFO_DEPTH=4): push 6 words on consecutive cycles with `cmd_valid` held. Required:
  - `cmd_ready` falls once `fifo_level` reaches 4.
  - Exactly 5 words are accepted before the first frame ends: one is popped at the start, so 4 remain buffered.
  - All accepted words are transmitted in order.
- Simultaneous push/pop: push while STOP is ending with `fifo_level`=2. Required: `fifo_level` stays 2 and the next START begins on the following cycle.
- Mid-frame reset: assert `rst` during DATA bit 3 with 2 words buffered. Required: `tx`=1 immediately, `fifo_level`=0, and no further frames after release.

Source files
------------

// File: rtl/cmd_uart_tx.sv
// Buffered UART command transmitter: valid/ready push into a FIFO, LSB-first serial frames on tx.
// Define CMD_UART_PARITY_EN to add one even-parity bit after the data bits of every frame.
module cmd_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_W-1:0]                cmd,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  output logic                             tx,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_W);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_W - 1);
  localparam logic [LW-1:0] L_FULL = LW'(FIFO_DEPTH);

`ifdef CMD_UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DATA_W-1:0] shift;
  logic [TW-1:0]     timer;
  logic [IW-1:0]     idx;
  logic              stop_cnt;
`ifdef CMD_UART_PARITY_EN
  logic              par;
`endif

  logic              push;
  logic              pop;
  logic              bit_end;
  logic              stop_end;
  logic              frame_next;
  logic [LW-1:0]     level_next;

  // Pop happens either from IDLE or at the very end of the last stop bit, giving gapless streaming.
  always_comb begin
    push       = cmd_valid && cmd_ready;
    bit_end    = (timer == T_LAST);
    stop_end   = (state == STOP) && bit_end && ((STOP_BITS == 1) || stop_cnt);
    pop        = (fifo_level != '0) && ((state == IDLE) || stop_end);
    level_next = fifo_level;
    if (push && !pop) begin
      level_next = fifo_level + LW'(1);
    end else if (!push && pop) begin
      level_next = fifo_level - LW'(1);
    end
    if (state == IDLE) begin
      frame_next = (fifo_level != '0);
    end else begin
      frame_next = !(stop_end && (fifo_level == '0));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      cmd_ready  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      fifo_level <= level_next;
      cmd_ready  <= (level_next != L_FULL);
      busy       <= frame_next || (level_next != '0);
    end
  end

  // Storage and the shift register are pure data and carry no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cmd;
    end
    if (pop) begin
      shift <= mem[rd_ptr];
`ifdef CMD_UART_PARITY_EN
      par   <= ^mem[rd_ptr];
`endif
    end else if ((state == DATA) && bit_end) begin
      shift <= shift >> 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      idx      <= '0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
    end else begin
      timer <= ((state == IDLE) || bit_end) ? '0 : timer + TW'(1);
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            idx   <= '0;
            tx    <= shift[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (idx == I_LAST) begin
`ifdef CMD_UART_PARITY_EN
              state <= PARITY;
              tx    <= par;
`else
              state    <= STOP;
              stop_cnt <= 1'b0;
              tx       <= 1'b1;
`endif
            end else begin
              idx <= idx + IW'(1);
              tx  <= shift[1];
            end
          end
        end
`ifdef CMD_UART_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (stop_end) begin
            if (pop) begin
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else if (bit_end) begin
            stop_cnt <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
